// File: rtl/voice_allocator.sv
// voice_allocator: sequential voice scheduler feeding the per-channel
// oscillator/envelope voices in front of multi_channel_mixer.
// Requests are accepted one at a time in IDLE. Each request then spends
// NUM_VOICES cycles in SCAN, examining one voice per cycle, and one cycle in
// COMMIT, where the result is applied.
// Voice choice for note-on: retrigger a gated voice already playing the same
// note, else take the lowest free voice, else steal the oldest voice.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req_valid     request present
//   req_ready     allocator can accept a request this cycle
//   req_on        1 = note-on, 0 = note-off
//   req_note      note number
//   sustain       sustain pedal (only with VOICE_ALLOC_SUSTAIN_EN)
//   gate          per-voice gate (registered)
//   voice_note    per-voice note, voice v at [v*NOTE_BITS +: NOTE_BITS] (registered)
//   trig          one-cycle retrigger pulse on the allocated voice
//   steal         one-cycle pulse when a gated voice was evicted
//   active_count  popcount of gate
//
// Optional feature macro: VOICE_ALLOC_SUSTAIN_EN (sustain pedal with held voices).
module voice_allocator #(
  parameter int NUM_VOICES = 12,
  parameter int NOTE_BITS  = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_on,
  input  logic [NOTE_BITS-1:0]              req_note,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                              sustain,
`endif
  output logic [NUM_VOICES-1:0]             gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]             trig,
  output logic                              steal,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int AW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(NUM_VOICES+1);
  localparam logic [AW-1:0] AGE_MAX  = AW'(NUM_VOICES-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_VOICES-1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic                 on_q;
  logic [NOTE_BITS-1:0] note_q;
  logic [NOTE_BITS-1:0] notes [NUM_VOICES];
  logic [AW-1:0]        ages  [NUM_VOICES];

  logic                 match_found;
  logic                 free_found;
  logic [IW-1:0]        match_idx;
  logic [IW-1:0]        free_idx;
  logic [IW-1:0]        old_idx;
  logic [AW-1:0]        old_age;
  logic [IW-1:0]        target;
  logic                 pending_release;

`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic [NUM_VOICES-1:0] held;
  logic                  sustain_q;
  logic                  pending;
  assign pending_release = pending;
`else
  assign pending_release = 1'b0;
`endif

  // A pending sustain release occupies one IDLE cycle, so no accept then.
  assign req_ready = (state == IDLE) && !pending_release;

  always_comb begin
    target = old_idx;
    if (match_found)     target = match_idx;
    else if (free_found) target = free_idx;
  end

  always_comb begin
    voice_note   = '0;
    active_count = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_note[i*NOTE_BITS +: NOTE_BITS] = notes[i];
      active_count = active_count + CW'(gate[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      gate        <= '0;
      trig        <= '0;
      steal       <= 1'b0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        notes[i] <= '0;
        ages[i]  <= '0;
      end
`ifdef VOICE_ALLOC_SUSTAIN_EN
      held      <= '0;
      sustain_q <= 1'b0;
      pending   <= 1'b0;
`endif
    end else begin
      trig  <= '0;
      steal <= 1'b0;

      unique case (state)
        IDLE: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
          if (pending) begin
            gate <= gate & ~held;
            held <= '0;
          end else
`endif
          if (req_valid) begin
            on_q        <= req_on;
            note_q      <= req_note;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            state       <= SCAN;
          end
        end

        SCAN: begin
          if (!match_found && gate[idx] && (notes[idx] == note_q)) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!free_found && !gate[idx]) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (ages[idx] > old_age) begin
            old_age <= ages[idx];
            old_idx <= idx;
          end
          if (idx == IDX_LAST) state <= COMMIT;
          else                 idx   <= idx + 1'b1;
        end

        COMMIT: begin
          state <= IDLE;
          if (on_q) begin
            // Age every gated voice, then the later assignment to the target
            // voice overrides its own increment with zero.
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              if (gate[i] && (ages[i] != AGE_MAX)) ages[i] <= ages[i] + 1'b1;
            end
            gate[target]  <= 1'b1;
            notes[target] <= note_q;
            ages[target]  <= '0;
            trig[target]  <= 1'b1;
            steal         <= !match_found && !free_found;
`ifdef VOICE_ALLOC_SUSTAIN_EN
            held[target]  <= 1'b0;
`endif
          end else if (match_found) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
            if (sustain) begin
              held[match_idx] <= 1'b1;
            end else begin
              gate[match_idx] <= 1'b0;
              held[match_idx] <= 1'b0;
            end
`else
            gate[match_idx] <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase

`ifdef VOICE_ALLOC_SUSTAIN_EN
      sustain_q <= sustain;
      // A new falling edge wins over clearing, so it is never lost.
      if (sustain_q && !sustain)           pending <= 1'b1;
      else if ((state == IDLE) && pending) pending <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Sequential voice scheduler in front of multi_channel_mixer and the per-channel oscillator/envelope voices.
- Accepts note-on/note-off requests one at a time and assigns each to one of NUM_VOICES channels.
- Drives per-voice gate, note and retrigger outputs, which feed the voices whose outputs enter the mixer.
- Voice choice priority: retrigger of an already-gated matching note, then lowest free voice, then steal of the oldest voice.

Parameters:
- NUM_VOICES, 12, number of voice channels; legal range 2..12, matching the mixer's input count.
- NOTE_BITS, 7, width of the note number.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  allocator can accept a request this cycle.
- req_on  input  1  1 = note-on, 0 = note-off.
- req_note  input  NOTE_BITS  note number.
- gate  output  NUM_VOICES  per-voice gate, registered.
- voice_note  output  NUM_VOICES*NOTE_BITS  per-voice note; voice v occupies bits [v*NOTE_BITS +: NOTE_BITS]; registered.
- trig  output  NUM_VOICES  one-cycle retrigger pulse on an allocated voice.
- steal  output  1  one-cycle pulse: the allocation evicted a gated voice.
- active_count  output  $clog2(NUM_VOICES+1)  popcount of gate; combinational from the gate register.

Behaviour:
- Reset: all outputs 0, all ages 0, FSM = IDLE, any pending request dropped.
  - Reset asserted mid-SCAN or mid-COMMIT aborts the request with no output change other than the clear.
- FSM states are IDLE, SCAN and COMMIT.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_on and req_note, set idx=0, go to SCAN.
  - SCAN: req_ready=0. Examine voice idx each cycle, idx 0..NUM_VOICES-1, so SCAN lasts NUM_VOICES cycles. Then go to COMMIT.
  - COMMIT: req_ready=0. Apply the result on this cycle's closing edge, then go to IDLE.
- Throughput: accept-to-next-accept is NUM_VOICES+2 cycles. Outputs change on the COMMIT edge, NUM_VOICES+1 cycles after the accepting edge.
- Candidates tracked during SCAN:
  - match: first voice with gate=1 and note==latched note.
  - free: first voice with gate=0.
  - oldest: voice with maximum age; ties go to the lowest index.
- Note-on resolution, in priority order:
  - If match exists: the voice keeps gate=1, trig[v] pulses, its age resets to 0, steal=0.
  - Else if free exists: gate[v]=1, voice_note[v]=note, trig[v] pulses, its age resets to 0.
  - Else: the oldest voice is overwritten with the new note, trig[v] pulses, its age resets to 0, and steal pulses.
  - On any note-on, every other gated voice's age increments, saturating at NUM_VOICES-1. Age width is $clog2(NUM_VOICES).
- Note-off resolution:
  - If match exists: gate[v]=0. voice_note[v] is retained so the release phase keeps its pitch. Ages are unchanged.
  - If no match: no-op, no pulses.
- trig and steal are high for exactly the one cycle after the COMMIT edge.
- req_note and req_on are ignored when the request is not accepted. No request is queued.
- Duplicate note-on while all voices are gated with that note: the match rule applies, so no steal occurs.

Optional Feature:
- Macro: VOICE_ALLOC_SUSTAIN_EN.
- When defined:
  - An extra input port `sustain` (1 bit) is present, plus an internal held[NUM_VOICES] register.
  - A note-off that matches while sustain=1 sets held[v]=1 and leaves gate[v]=1.
  - A note-on that matches a held voice clears held[v] and retriggers it.
  - A falling edge of sustain sets a pending flag in any state.
  - On the next IDLE cycle with pending set, that cycle is spent clearing gate and held for all held voices. req_ready=0 for that cycle and pending is cleared.
  - Reset clears held and pending.
- When undefined: no sustain port; note-off clears gate immediately as described above.

Test Plan:
- After reset (bench uses NUM_VOICES=4), note-on 60 -> COMMIT edge 5 cycles after accept: gate=0001, voice_note[0]=60, trig=0001 for 1 cycle, active_count=1, req_ready high again on the next cycle.
- Note-on 60, 62, 64, 65, then 67 -> voice 0 (oldest, age 3) is reloaded with 67, steal=1 for 1 cycle, trig=0001, gate=1111.
- With 60 on voice 0 and 62 on voice 1, note-on 60 again -> trig=0001, steal=0, gate unchanged, age[0]=0, age[1]=1.
- Note-off 62 with 62 on voice 1 -> gate[1]=0, voice_note[1] still 62. A following note-off 70 produces no change and no pulses.
- Assert rst during SCAN of a note-on with 2 voices gated -> all outputs 0 next cycle, FSM IDLE, req_ready=1.
- VOICE_ALLOC_SUSTAIN_EN defined: sustain=1, note-on 60, note-off 60 -> gate[0] stays 1. Drop sustain -> gate[0]=0 in the first IDLE cycle, with req_ready=0 for that one cycle.
